conv_window_gen: RTL and testbench
==================================

Name: conv_window_gen

Overview:
- Streaming KxK sliding-window generator for the CNN datapath.
- Accepts one pixel per valid cycle in raster order and keeps K-1 row line buffers.
- Emits one flattened KxK window per valid output position (valid convolution, no padding).
- Sits directly upstream of the per-channel queue_reg buffers and conv MAC array; its window taps feed those buffers.

Parameters:
- WIDTH, 8, pixel bit width
- IMG_W, 28, image width in pixels (>= K)
- IMG_H, 28, image height in pixels (>= K)
- K, 3, window size (2..5)

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous active-low reset
- pix_vld  input  1  pix_in valid this cycle
- sof  input  1  start of frame; qualified by pix_vld; marks the pixel as (row 0, col 0)
- pix_in  input  WIDTH  pixel data, raster order
- win_vld  output  1  win_data holds a complete window this cycle (single-cycle pulse)
- win_data  output  WIDTH*K*K  flattened window
- busy  output  1  high from first accepted pixel of a frame until its last pixel is accepted

Behaviour:
- Reset is asynchronous active-low: all registers clear immediately on rst=0. Cleared state:
  - col_cnt=0, row_cnt=0
  - win_vld=0, win_data=0, busy=0
  - line buffers and window register cleared
- Reset mid-frame discards the partial frame. The next accepted pixel is (0,0) regardless of sof.
- Counters:
  - col_cnt runs 0..IMG_W-1; row_cnt runs 0..IMG_H-1.
  - Each accepted pixel advances col_cnt.
  - At col IMG_W-1, col_cnt wraps to 0 and row_cnt increments.
  - At (IMG_H-1, IMG_W-1), both wrap to 0: back-to-back frames need no gap.
- sof:
  - pix_vld=1 and sof=1: pixel is (0,0) and counters resync. After this pixel, col_cnt=1, row_cnt=0.
  - sof without pix_vld is ignored.
- Line buffers: K-1 shift chains, each IMG_W deep.
  - On pix_vld, chain 0 shifts in pix_in; chain j shifts in the tail of chain j-1.
  - Line buffers are not cleared at frame wrap; stale data never reaches a valid window.
- Window register (KxK):
  - On pix_vld, every row shifts left one column.
  - The new rightmost column, top to bottom, is: tail of chain K-2, ..., tail of chain 0, pix_in.
- Packing: win_data[WIDTH*(r*K+c) +: WIDTH] = window row r (0 = top/oldest), column c (0 = leftmost).
- Output timing:
  - win_vld=1 on the cycle after a pixel is accepted with row>=K-1 and col>=K-1 (latency 1).
  - win_data holds its value when win_vld=0.
- Window count per frame: exactly (IMG_W-K+1)*(IMG_H-K+1); 676 at defaults.
- Gaps: pix_vld gaps are allowed at any point. Without pix_vld, state holds and win_vld=0.
- busy:
  - Rises on the accepted (0,0) pixel.
  - Falls on the cycle after the last pixel (IMG_H-1, IMG_W-1) is accepted.
- No backpressure: the consumer must accept every win_vld pulse.
- Widths: counters use $clog2(IMG_W) and $clog2(IMG_H) bits; no arithmetic on pixel data.

Optional Feature:
- Macro: CONV_WINDOW_GEN_FRAME_DONE_EN.
- Defined:
  - Adds output frame_done (1 bit, resets to 0).
  - frame_done pulses high for one cycle, coincident with the final win_vld of a frame (window at bottom-right).
  - Does not pulse if reset or sof occurs before the frame completes.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
- Reset: assert rst=0 asynchronously mid-cycle -> win_vld=0, win_data=0, busy=0 immediately, without waiting for a clock edge.
- Basic 5x5 (IMG_W=5, IMG_H=5, K=3): pixels 0..24, pix_vld continuous, sof on pixel 0 -> exactly 9 win_vld pulses.
  - First pulse one cycle after pixel 12: rows {0,1,2},{5,6,7},{10,11,12}.
  - Last pulse: rows {12,13,14},{17,18,19},{22,23,24}.
- Gapped input: same 5x5 frame with random pix_vld gaps (~50% duty) -> same 9 windows, same order and values; win_vld never high during idle.
- sof resync: 5x5 with sof re-asserted on the 8th pixel -> counters restart there; no window until that frame's pixel (2,2); 9 correct windows follow.
- Defaults, two back-to-back 28x28 frames with no gap -> exactly 676 win_vld per frame; busy stays high across the frame boundary. If CONV_WINDOW_GEN_FRAME_DONE_EN is defined, frame_done pulses exactly twice.
- Reset mid-frame: at pixel 40 of a 28x28 frame, pulse rst low, then stream a full frame without sof -> first window comes from the new frame's pixels (2,2) neighbourhood; 676 windows total; no stale window.

Source files
------------

// File: rtl/conv_window_gen_if.sv
// conv_window_gen_if: pixel-in / window-out bundle for conv_window_gen
// frame_done is present only when CONV_WINDOW_GEN_FRAME_DONE_EN is defined
interface conv_window_gen_if #(
    parameter int WIDTH = 8,
    parameter int K     = 3
);
    logic                   pix_vld;
    logic                   sof;
    logic [WIDTH-1:0]       pix_in;
    logic                   win_vld;
    logic [WIDTH*K*K-1:0]   win_data;
    logic                   busy;
`ifdef CONV_WINDOW_GEN_FRAME_DONE_EN
    logic                   frame_done;
    modport master (output pix_vld, sof, pix_in, input win_vld, win_data, busy, frame_done);
    modport slave  (input pix_vld, sof, pix_in, output win_vld, win_data, busy, frame_done);
`else
    modport master (output pix_vld, sof, pix_in, input win_vld, win_data, busy);
    modport slave  (input pix_vld, sof, pix_in, output win_vld, win_data, busy);
`endif
endinterface

// File: rtl/conv_window_gen.sv
// conv_window_gen: streaming KxK sliding-window generator with K-1 line buffers
// Optional frame_done pulse enabled by defining CONV_WINDOW_GEN_FRAME_DONE_EN
module conv_window_gen #(
    parameter int WIDTH = 8,
    parameter int IMG_W = 28,
    parameter int IMG_H = 28,
    parameter int K     = 3
) (
    input  logic              clk,
    input  logic              rst,
    conv_window_gen_if.slave  bus
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [CW-1:0] COL_WIN  = CW'(K - 1);
    localparam logic [RW-1:0] ROW_WIN  = RW'(K - 1);

    logic [CW-1:0]        col_cnt, cur_col;
    logic [RW-1:0]        row_cnt, cur_row;
    logic [WIDTH-1:0]     line_buf [K-1][IMG_W];
    logic [WIDTH-1:0]     win      [K][K];
    logic [WIDTH-1:0]     win_next [K][K];
    logic [WIDTH*K*K-1:0] win_flat;
    logic                 busy_q, at_first, at_last, win_pos;

    // Position of the pixel on the input; sof forces it to (0,0)
    always_comb begin
        cur_col  = bus.sof ? '0 : col_cnt;
        cur_row  = bus.sof ? '0 : row_cnt;
        at_first = (cur_col == '0) && (cur_row == '0);
        at_last  = (cur_col == COL_LAST) && (cur_row == ROW_LAST);
        win_pos  = (cur_col >= COL_WIN) && (cur_row >= ROW_WIN);
    end

    // Raster counters, wrapping at row and frame ends so frames can run back to back
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col_cnt <= '0;
            row_cnt <= '0;
        end else if (bus.pix_vld) begin
            col_cnt <= (cur_col == COL_LAST) ? '0 : cur_col + 1'b1;
            row_cnt <= (cur_col != COL_LAST) ? cur_row : (cur_row == ROW_LAST) ? '0 : cur_row + 1'b1;
        end
    end

    // Line buffers: chain 0 takes the new pixel, chain j takes the tail of chain j-1
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            line_buf <= '{default: '0};
        end else if (bus.pix_vld) begin
            line_buf[0][0] <= bus.pix_in;
            for (int j = 1; j < K - 1; j++)
                line_buf[j][0] <= line_buf[j-1][IMG_W-1];
            for (int j = 0; j < K - 1; j++)
                for (int i = 1; i < IMG_W; i++)
                    line_buf[j][i] <= line_buf[j][i-1];
        end
    end

    // Next window: shift left, new right column is the oldest chain tail down to pix_in
    always_comb begin
        win_next = '{default: '0};
        win_flat = '0;
        for (int r = 0; r < K; r++)
            for (int c = 0; c < K - 1; c++)
                win_next[r][c] = win[r][c+1];
        for (int r = 0; r < K - 1; r++)
            win_next[r][K-1] = line_buf[K-2-r][IMG_W-1];
        win_next[K-1][K-1] = bus.pix_in;
        for (int r = 0; r < K; r++)
            for (int c = 0; c < K; c++)
                win_flat[WIDTH*(r*K+c) +: WIDTH] = win_next[r][c];
    end

    // Window register, registered outputs and frame-in-progress flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            win          <= '{default: '0};
            bus.win_vld  <= 1'b0;
            bus.win_data <= '0;
            busy_q       <= 1'b0;
        end else begin
            bus.win_vld <= bus.pix_vld && win_pos;
            if (bus.pix_vld) begin
                win    <= win_next;
                busy_q <= !at_last;
                if (win_pos)
                    bus.win_data <= win_flat;
            end
        end
    end

    // A (0,0) pixel on the input raises busy at once, so back-to-back frames never drop it
    assign bus.busy = busy_q || (rst && bus.pix_vld && at_first);

`ifdef CONV_WINDOW_GEN_FRAME_DONE_EN
    // Pulses alongside the bottom-right window of a frame
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            bus.frame_done <= 1'b0;
        else
            bus.frame_done <= bus.pix_vld && at_last;
    end
`endif
endmodule

// File: tb/tb_conv_window_gen.sv
// tb_conv_window_gen: randomized bench for conv_window_gen against an image-array reference
// Checks frame_done as well when CONV_WINDOW_GEN_FRAME_DONE_EN is defined
module tb_conv_window_gen;
    localparam int WIDTH = 8;
    localparam int K     = 3;
    localparam int DW    = WIDTH * K * K;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    conv_window_gen_if #(.WIDTH(WIDTH), .K(K)) sm_if ();
    conv_window_gen_if #(.WIDTH(WIDTH), .K(K)) lg_if ();

    conv_window_gen #(.WIDTH(WIDTH), .IMG_W(5), .IMG_H(5), .K(K)) dut_sm (
        .clk(clk), .rst(rst), .bus(sm_if.slave));
    conv_window_gen #(.WIDTH(WIDTH), .IMG_W(28), .IMG_H(28), .K(K)) dut_lg (
        .clk(clk), .rst(rst), .bus(lg_if.slave));

    int img_w [2] = '{5, 28};
    int img_h [2] = '{5, 28};
    int pos [2];
    logic [WIDTH-1:0] img [2][784];
    logic [DW-1:0] exp_data [2];
    int win_seen [2];
    int fd_seen;
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One input cycle to dut d; the model places the pixel in its frame image and predicts outputs
    task automatic step(input int d, input logic vld, input logic s, input logic [WIDTH-1:0] pix);
        logic ev, ov;
        logic [DW-1:0] od;
        int r, c;
`ifdef CONV_WINDOW_GEN_FRAME_DONE_EN
        logic efd, ofd;
`endif
        sm_if.pix_vld = (d == 0) && vld;
        sm_if.sof     = s;
        sm_if.pix_in  = pix;
        lg_if.pix_vld = (d == 1) && vld;
        lg_if.sof     = s;
        lg_if.pix_in  = pix;
        #1;
        check("busy_sm", sm_if.busy, (pos[0] != 0) || (d == 0 && vld));
        check("busy_lg", lg_if.busy, (pos[1] != 0) || (d == 1 && vld));
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            ev = 1'b0;
`ifdef CONV_WINDOW_GEN_FRAME_DONE_EN
            efd = 1'b0;
`endif
            if (k == d && vld) begin
                if (s) pos[k] = 0;
                r = pos[k] / img_w[k];
                c = pos[k] % img_w[k];
                img[k][pos[k]] = pix;
                if (r >= K - 1 && c >= K - 1) begin
                    ev = 1'b1;
                    for (int i = 0; i < K; i++)
                        for (int j = 0; j < K; j++)
                            exp_data[k][WIDTH*(i*K+j) +: WIDTH] = img[k][(r-K+1+i)*img_w[k] + c-K+1+j];
`ifdef CONV_WINDOW_GEN_FRAME_DONE_EN
                    efd = (r == img_h[k] - 1) && (c == img_w[k] - 1);
`endif
                end
                pos[k] = (pos[k] + 1) % (img_w[k] * img_h[k]);
            end
            ov = (k == 0) ? sm_if.win_vld : lg_if.win_vld;
            od = (k == 0) ? sm_if.win_data : lg_if.win_data;
            if (ov) win_seen[k]++;
            check((k == 0) ? "win_vld_sm" : "win_vld_lg", ov, ev);
            check((k == 0) ? "win_data_sm" : "win_data_lg", od, exp_data[k]);
`ifdef CONV_WINDOW_GEN_FRAME_DONE_EN
            ofd = (k == 0) ? sm_if.frame_done : lg_if.frame_done;
            if (ofd) fd_seen++;
            check((k == 0) ? "frame_done_sm" : "frame_done_lg", ofd, efd);
`endif
        end
    endtask

    // Asynchronous reset pulse in the middle of a cycle; outputs must clear before any edge
    task automatic do_reset();
        #2 rst = 1'b0;
        #1;
        check("rst_vld_sm", sm_if.win_vld, 0);
        check("rst_data_sm", sm_if.win_data, 0);
        check("rst_busy_sm", sm_if.busy, 0);
        check("rst_vld_lg", lg_if.win_vld, 0);
        check("rst_data_lg", lg_if.win_data, 0);
        check("rst_busy_lg", lg_if.busy, 0);
`ifdef CONV_WINDOW_GEN_FRAME_DONE_EN
        check("rst_fd_sm", sm_if.frame_done, 0);
        check("rst_fd_lg", lg_if.frame_done, 0);
`endif
        @(posedge clk);
        #1 rst = 1'b1;
        pos = '{0, 0};
        exp_data = '{'0, '0};
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

    initial begin
        int fw [9] = '{0, 1, 2, 5, 6, 7, 10, 11, 12};
        int lw [9] = '{12, 13, 14, 17, 18, 19, 22, 23, 24};
        logic [DW-1:0] first_exp, last_exp;
        for (int i = 0; i < 9; i++) begin
            first_exp[WIDTH*i +: WIDTH] = WIDTH'(fw[i]);
            last_exp[WIDTH*i +: WIDTH]  = WIDTH'(lw[i]);
        end
        pos = '{0, 0};
        exp_data = '{'0, '0};
        fd_seen = 0;
        sm_if.pix_vld = 0; sm_if.sof = 0; sm_if.pix_in = '0;
        lg_if.pix_vld = 0; lg_if.sof = 0; lg_if.pix_in = '0;
        repeat (3) @(posedge clk);
        #1;
        check("init_vld", sm_if.win_vld, 0);
        check("init_data", sm_if.win_data, 0);
        check("init_busy", sm_if.busy, 0);
        rst = 1'b1;

        // Basic continuous 5x5 frame of pixels 0..24
        win_seen = '{0, 0};
        for (int i = 0; i < 25; i++) begin
            step(0, 1, i == 0, WIDTH'(i));
            if (i == 12) check("first_win", sm_if.win_data, first_exp);
            if (i == 24) check("last_win", sm_if.win_data, last_exp);
        end
        step(0, 0, 0, '0);
        check("cnt_basic", win_seen[0], 9);

        // Same frame with random idle gaps
        win_seen = '{0, 0};
        for (int i = 0; i < 25; i++) begin
            while ($urandom_range(0, 1) == 1) step(0, 0, $urandom_range(0, 1) == 1, WIDTH'($urandom));
            step(0, 1, i == 0, WIDTH'(i));
        end
        step(0, 0, 0, '0);
        check("cnt_gapped", win_seen[0], 9);

        // Reset right after a window has been produced
        for (int i = 0; i < 13; i++) step(0, 1, i == 0, WIDTH'($urandom));
        check("win_before_rst", sm_if.win_vld, 1);
        do_reset();

        // sof re-asserted on the 8th pixel restarts the frame
        win_seen = '{0, 0};
        for (int i = 0; i < 7; i++) step(0, 1, i == 0, WIDTH'($urandom));
        for (int i = 0; i < 25; i++) begin
            step(0, 1, i == 0, WIDTH'($urandom));
            if (i == 11) check("no_early_win", win_seen[0], 0);
        end
        step(0, 0, 0, '0);
        check("cnt_sof", win_seen[0], 9);

        // Two back-to-back 28x28 frames, no gap, sof only on the first
        fd_seen = 0;
        for (int f = 0; f < 2; f++) begin
            win_seen = '{0, 0};
            for (int i = 0; i < 784; i++) begin
                step(1, 1, f == 0 && i == 0, WIDTH'($urandom));
                if (f == 1 && i == 0) check("busy_b2b", lg_if.busy, 1);
            end
            check(f == 0 ? "cnt_frame0" : "cnt_frame1", win_seen[1], 676);
        end
        step(1, 0, 0, '0);
        check("busy_idle", lg_if.busy, 0);
`ifdef CONV_WINDOW_GEN_FRAME_DONE_EN
        check("fd_count", fd_seen, 2);
`endif

        // Reset at pixel 40, then a full frame without sof
        for (int i = 0; i < 40; i++) step(1, 1, i == 0, WIDTH'($urandom));
        do_reset();
        win_seen = '{0, 0};
        for (int i = 0; i < 784; i++) begin
            while ($urandom_range(0, 7) == 0) step(1, 0, 0, WIDTH'($urandom));
            step(1, 1, 0, WIDTH'($urandom));
            if (i == 2 * 28 + 1) check("no_stale_win", win_seen[1], 0);
        end
        step(1, 0, 0, '0);
        check("cnt_after_rst", win_seen[1], 676);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
